// File: rtl/ricosoc_uart_pkg.sv
// Shared constants and state encodings for the memory-mapped UART.
// Register offsets, STATUS bit positions, FSM states, divider floor.
package ricosoc_uart_pkg;

    localparam logic [3:0] OFF_DIV    = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_RSVD   = 4'hC;

    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_BUSY   = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;

    localparam logic [31:0] MIN_DIV = 32'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    function automatic logic [31:0] bit_period(input logic [31:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/ricosoc_uart_rx.sv
// UART receiver: input synchroniser, mid-bit sampler and frame FSM.
// Emits one-cycle done/ferr pulses; the byte is held on data.
module ricosoc_uart_rx
    import ricosoc_uart_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    input  logic [31:0] period,
    output logic        done,
    output logic        ferr,
    output logic [7:0]  data
);

    logic        sync1;
    logic        sync2;
    logic        prev;
    rx_state_t   state;
    rx_state_t   state_n;
    logic [31:0] cnt;
    logic [31:0] cnt_n;
    logic [31:0] per;
    logic [31:0] per_n;
    logic [2:0]  bidx;
    logic [2:0]  bidx_n;
    logic [7:0]  sh;
    logic [7:0]  sh_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
            state <= RX_IDLE;
            cnt   <= '0;
            per   <= MIN_DIV;
            bidx  <= '0;
            sh    <= '0;
        end else begin
            sync1 <= ser_rx;
            sync2 <= sync1;
            prev  <= sync2;
            state <= state_n;
            cnt   <= cnt_n;
            per   <= per_n;
            bidx  <= bidx_n;
            sh    <= sh_n;
        end
    end

    // START waits half a bit so later full-bit steps land mid-bit
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        per_n   = per;
        bidx_n  = bidx;
        sh_n    = sh;
        done    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_n = '0;
                if (prev && !sync2) begin
                    state_n = RX_START;
                    per_n   = period;
                end
            end
            RX_START: begin
                if (cnt == (per >> 1) - 32'd1) begin
                    cnt_n   = '0;
                    bidx_n  = '0;
                    state_n = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == per - 32'd1) begin
                    cnt_n  = '0;
                    sh_n   = {sync2, sh[7:1]};
                    bidx_n = bidx + 3'd1;
                    if (bidx == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == per - 32'd1) begin
                    cnt_n = '0;
                    if (sync2) begin
                        done    = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                cnt_n = '0;
                if (sync2) begin
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign data = sh;

endmodule

// File: rtl/ricosoc_uart.sv
// Memory-mapped UART: bus decode, registers, TX path, RX flags.
// Register window: DIV, DATA, STATUS, reserved.
module ricosoc_uart
    import ricosoc_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        ser_tx,
    input  logic        ser_rx,
    output logic        irq_rx
);

    logic [31:0] div;
    logic [31:0] period;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        rx_ferr;
    logic [7:0]  rx_data;

    tx_state_t   tx_state;
    tx_state_t   tx_state_n;
    logic [31:0] tx_cnt;
    logic [31:0] tx_cnt_n;
    logic [31:0] tx_per;
    logic [31:0] tx_per_n;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_n;
    logic [7:0]  tx_sh;
    logic [7:0]  tx_sh_n;
    logic        tx_busy;

    logic        hit;
    logic        is_rd;
    logic        sel_div;
    logic        sel_data;
    logic        sel_stat;
    logic        data_wr;
    logic        accept;
    logic        tx_go;
    logic        rd_data;
    logic        rd_stat;
    logic [31:0] rd_val;
    logic        unused_ok;

    assign period   = bit_period(div);
    assign tx_busy  = tx_state != TX_IDLE;
    assign hit      = iomem_valid
                   && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign is_rd    = iomem_wstrb == 4'b0000;
    assign sel_div  = {iomem_addr[3:2], 2'b00} == OFF_DIV;
    assign sel_data = {iomem_addr[3:2], 2'b00} == OFF_DATA;
    assign sel_stat = {iomem_addr[3:2], 2'b00} == OFF_STATUS;
    assign data_wr  = sel_data && iomem_wstrb[0];
    // a byte write is held off while a frame is still on the wire
    assign accept   = hit && !iomem_ready && !(data_wr && tx_busy);
    assign tx_go    = accept && data_wr;
    assign rd_data  = accept && is_rd && sel_data;
    assign rd_stat  = accept && is_rd && sel_stat;
    assign irq_rx   = rx_valid;
    assign unused_ok = ^iomem_addr[1:0];

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_div:  rd_val = div;
            sel_data: rd_val = rx_valid ? {24'h0, rx_byte}
                                        : 32'hFFFF_FFFF;
            sel_stat: begin
                rd_val[ST_RX_VALID]  = rx_valid;
                rd_val[ST_TX_BUSY]   = tx_busy;
                rd_val[ST_OVERRUN]   = overrun;
                rd_val[ST_FRAME_ERR] = frame_err;
            end
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            div         <= DEFAULT_DIV;
        end else begin
            iomem_ready <= accept;
            if (accept) begin
                iomem_rdata <= is_rd ? rd_val : '0;
                if (sel_div) begin
                    for (int i = 0; i < 4; i++) begin
                        if (iomem_wstrb[i]) begin
                            div[8*i +: 8] <= iomem_wdata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    // a read racing a new byte hands out the old one, nothing is lost
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_done) begin
                rx_byte  <= rx_data;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (rx_done && rx_valid && !rd_data) begin
                overrun <= 1'b1;
            end else if (rd_stat) begin
                overrun <= 1'b0;
            end
            if (rx_ferr) begin
                frame_err <= 1'b1;
            end else if (rd_stat) begin
                frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_per   <= MIN_DIV;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_per   <= tx_per_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 32'd1;
        tx_per_n   = tx_per;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_go) begin
                    tx_state_n = TX_START;
                    tx_per_n   = period;
                    tx_sh_n    = iomem_wdata[7:0];
                end
            end
            TX_START: begin
                if (tx_cnt == tx_per - 32'd1) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt == tx_per - 32'd1) begin
                    tx_cnt_n = '0;
                    tx_sh_n  = {1'b1, tx_sh[7:1]};
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt == tx_per - 32'd1) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        ser_tx = 1'b1;
        unique case (tx_state)
            TX_START: ser_tx = 1'b0;
            TX_DATA:  ser_tx = tx_sh[0];
            default:  ser_tx = 1'b1;
        endcase
    end

    ricosoc_uart_rx u_rx (
        .clk    (clk),
        .resetn (resetn),
        .ser_rx (ser_rx),
        .period (period),
        .done   (rx_done),
        .ferr   (rx_ferr),
        .data   (rx_data)
    );

endmodule

// File: doc/ricosoc_uart.md
RICOSOC_UART -- requirements
Module: ricosoc_uart

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000, base of the 16-byte register window.
REQ-002 Parameter DEFAULT_DIV, default 32'd104, reset value of the clock divider.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 iomem_valid  in  1  bus request from the CPU side.
REQ-006 iomem_ready  out  1  transfer-complete strobe.
REQ-007 iomem_wstrb  in  4  byte write enables; 4'b0000 means read.
REQ-008 iomem_addr  in  32  byte address.
REQ-009 iomem_wdata  in  32  write data.
REQ-010 iomem_rdata  out  32  read data, valid while iomem_ready=1.
REQ-011 ser_tx  out  1  serial transmit line, idle high.
REQ-012 ser_rx  in  1  serial receive line, asynchronous to clk.
REQ-013 irq_rx  out  1  high while a received byte is pending.

Function
REQ-014 Hit = iomem_valid && iomem_addr[31:4]==BASE_ADDR[31:4]; misses are ignored and never cause iomem_ready.
REQ-015 Offset 0x0 DIV (R/W, byte-wise per wstrb); 0x4 DATA; 0x8 STATUS (RO); 0xC reads 0, writes ignored.
REQ-016 iomem_ready is registered, asserts 1 cycle after a hit with ready low, and stays high exactly one cycle per transfer.
REQ-017 DATA write (wstrb[0]=1) while TX busy is stalled: ready is withheld until TX returns to IDLE, then the byte is accepted with ready.
REQ-018 DATA read returns {24'h0, rx_byte} and clears rx_valid when rx_valid=1; otherwise it returns 32'hFFFF_FFFF.
REQ-019 STATUS read = {28'h0, frame_err, overrun, tx_busy, rx_valid}; the read clears frame_err and overrun.
REQ-020 Bit period = max(DIV, 4) clk cycles.
REQ-021 TX FSM: IDLE -> START (ser_tx=0, one bit) -> DATA (8 bits, LSB first) -> STOP (ser_tx=1, one bit) -> IDLE; tx_busy=1 outside IDLE.
REQ-022 The DIV value is sampled at frame start; a DIV write mid-frame affects the next frame only.
REQ-023 ser_rx passes through a 2-flop synchroniser before any use.
REQ-024 RX FSM: IDLE detects a falling edge -> START samples at half-period.
REQ-025 In START, a low sample goes to DATA; a high sample (glitch) returns to IDLE with no flag set.
REQ-026 DATA samples 8 bits at mid-bit, LSB first, then enters STOP.
REQ-027 STOP with a high sample loads rx_byte and sets rx_valid; a low sample sets frame_err, discards the byte and waits for the line to go high before IDLE.
REQ-028 A byte completing while rx_valid=1 overwrites rx_byte and sets overrun.
REQ-029 A DATA read coinciding with a byte completion returns the old byte and leaves rx_valid=1 with the new byte.
REQ-030 irq_rx = rx_valid.

Reset
REQ-031 On resetn low: ser_tx=1, iomem_ready=0, iomem_rdata=0, DIV=DEFAULT_DIV, rx_valid=overrun=frame_err=0, both FSMs IDLE, synchroniser flops=1.
REQ-032 Reset mid-frame aborts the frame immediately; the line returns high with no partial byte retained.

Structure
REQ-033 Package ricosoc_uart_pkg holds the register offsets, the STATUS bit indices, the TX/RX state encodings and the minimum-divider constant 4.
REQ-034 The RX path (synchroniser, bit timer, FSM) is sub-module ricosoc_uart_rx; the TX path and the bus logic live in the top level.

Verification
REQ-035 DIV=4, write 0x0000_00A5 to DATA -> ser_tx: low 4 cycles, bits 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; STATUS bit1 high throughout.
REQ-036 Two back-to-back DATA writes 0x11, 0x22 -> second ready delayed until first STOP ends; both frames on ser_tx in order.
REQ-037 Drive frame 0x3C on ser_rx at DIV=8 -> irq_rx=1; DATA read returns 0x0000_003C; next DATA read returns 0xFFFF_FFFF.
REQ-038 Two frames 0x01, 0x02 without a read -> DATA returns 0x02; STATUS returns 0x5; second STATUS read returns 0x1.
REQ-039 1-cycle low glitch on ser_rx, and a frame with a low stop bit -> glitch yields no flags; the bad frame yields STATUS bit3=1, rx_valid=0.
REQ-040 Assert resetn low mid TX frame -> ser_tx=1 within the same cycle; DIV reads back DEFAULT_DIV; no iomem_ready pending.
